// File: rtl/axil2mpi_master.sv
// AXI4-Lite slave to MPI register-bus initiator bridge.
// AW and W are taken together as one write. Only one MPI access is in flight at a time.
// Simultaneous read and write requests are served round-robin.
module axil2mpi_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int CPU_ADDR_WIDTH = 12,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int RD_LATENCY     = 1
) (
    input  logic                        clks,
    input  logic                        reset_n,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    input  logic [CPU_DATA_WIDTH-1:0]   s_wdata,
    input  logic [CPU_DATA_WIDTH/8-1:0] s_wstrb,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    output logic [1:0]                  s_bresp,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic [CPU_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        cpu_wr,
    output logic [CPU_ADDR_WIDTH-1:0]   cpu_wr_addr,
    output logic [CPU_DATA_WIDTH-1:0]   cpu_data_in,
    output logic                        cpu_rd,
    input  logic [CPU_DATA_WIDTH-1:0]   cpu_data_out
);

    localparam int         STRB_WIDTH   = CPU_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [3:0] RD_WAIT_INIT = 4'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_EXEC = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        RD_RESP = 3'd5
    } state_t;

    // A write is only legal to the register file when every byte lane is enabled.
    function automatic logic all_ones(input logic [STRB_WIDTH-1:0] v);
        return &v;
    endfunction

    state_t                    state_r;
    logic                      prio_wr_r;
    logic [CPU_ADDR_WIDTH-1:0] addr_r;
    logic [CPU_DATA_WIDTH-1:0] data_r;
    logic                      strb_ok_r;
    logic                      cpu_wr_r;
    logic                      cpu_rd_r;
    logic                      bvalid_r;
    logic [1:0]                bresp_r;
    logic                      rvalid_r;
    logic [CPU_DATA_WIDTH-1:0] rdata_r;
    logic [3:0]                cnt_r;

    logic wr_cand_s;
    logic rd_cand_s;
    logic grant_wr_s;
    logic grant_rd_s;
    logic unused_addr_bits_s;

    // Byte-offset bits and bits above the word address are aliased away.
    assign unused_addr_bits_s = ^{s_awaddr[AXI_ADDR_WIDTH-1:CPU_ADDR_WIDTH+2], s_awaddr[1:0],
                                  s_araddr[AXI_ADDR_WIDTH-1:CPU_ADDR_WIDTH+2], s_araddr[1:0]};

    // Round-robin grant; readies are only ever offered from IDLE.
    always_comb begin
        wr_cand_s  = s_awvalid && s_wvalid;
        rd_cand_s  = s_arvalid;
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        if (state_r == IDLE) begin
            grant_wr_s = wr_cand_s && (!rd_cand_s || prio_wr_r);
            grant_rd_s = rd_cand_s && (!wr_cand_s || !prio_wr_r);
        end else begin
            grant_wr_s = 1'b0;
            grant_rd_s = 1'b0;
        end
    end

    assign s_awready   = grant_wr_s;
    assign s_wready    = grant_wr_s;
    assign s_arready   = grant_rd_s;
    assign s_bvalid    = bvalid_r;
    assign s_bresp     = bresp_r;
    assign s_rvalid    = rvalid_r;
    assign s_rdata     = rdata_r;
    assign s_rresp     = RESP_OKAY;
    assign cpu_wr      = cpu_wr_r;
    assign cpu_rd      = cpu_rd_r;
    assign cpu_wr_addr = addr_r;
    assign cpu_data_in = data_r;

    // Transaction FSM with registered MPI strobes and AXI response channels.
    always_ff @(posedge clks or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            prio_wr_r <= 1'b1;
            addr_r    <= '0;
            data_r    <= '0;
            strb_ok_r <= 1'b0;
            cpu_wr_r  <= 1'b0;
            cpu_rd_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            cnt_r     <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_wr_s) begin
                        addr_r    <= s_awaddr[CPU_ADDR_WIDTH+1:2];
                        data_r    <= s_wdata;
                        strb_ok_r <= all_ones(s_wstrb);
                        cpu_wr_r  <= all_ones(s_wstrb);
                        prio_wr_r <= 1'b0;
                        state_r   <= WR_EXEC;
                    end else if (grant_rd_s) begin
                        addr_r    <= s_araddr[CPU_ADDR_WIDTH+1:2];
                        cpu_rd_r  <= 1'b1;
                        prio_wr_r <= 1'b1;
                        state_r   <= RD_ADDR;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                WR_EXEC: begin
                    cpu_wr_r <= 1'b0;
                    bvalid_r <= 1'b1;
                    bresp_r  <= strb_ok_r ? RESP_OKAY : RESP_SLVERR;
                    state_r  <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_bready) begin
                        bvalid_r <= 1'b0;
                        bresp_r  <= RESP_OKAY;
                        state_r  <= IDLE;
                    end else begin
                        state_r  <= WR_RESP;
                    end
                end
                RD_ADDR: begin
                    cpu_rd_r <= 1'b0;
                    cnt_r    <= RD_WAIT_INIT;
                    state_r  <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        rdata_r  <= cpu_data_out;
                        rvalid_r <= 1'b1;
                        state_r  <= RD_RESP;
                    end else begin
                        cnt_r    <= cnt_r - 4'd1;
                    end
                end
                RD_RESP: begin
                    if (s_rready) begin
                        rvalid_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r  <= RD_RESP;
                    end
                end
                default: begin
                    cpu_wr_r <= 1'b0;
                    cpu_rd_r <= 1'b0;
                    bvalid_r <= 1'b0;
                    rvalid_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil2mpi_master.sv
// Directed, table-driven bench for axil2mpi_master with a behavioural register file.
// Word 4 of the register file reads back as word 2 + word 3.
module tb_axil2mpi_master;

    logic clks    = 1'b0;
    logic reset_n = 1'b0;
    always #5 clks = ~clks;

    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
    logic [31:0] s_awaddr = 32'h0, s_wdata = 32'h0, s_araddr = 32'h0;
    logic [3:0]  s_wstrb = 4'h0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, cpu_wr, cpu_rd;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, cpu_data_in, cpu_data_out;
    logic [11:0] cpu_wr_addr;

    axil2mpi_master dut (
        .clks(clks), .reset_n(reset_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_data_in(cpu_data_in),
        .cpu_rd(cpu_rd), .cpu_data_out(cpu_data_out)
    );

    // Second instance with a 3-cycle read latency, read path only.
    logic        s3_arvalid = 1'b0, s3_rready = 1'b0;
    logic [31:0] s3_araddr = 32'h0;
    logic        s3_arready, s3_rvalid, cpu_wr3, cpu_rd3;
    logic        unused_awready3, unused_wready3, unused_bvalid3;
    logic [1:0]  unused_bresp3, unused_rresp3;
    logic [31:0] s3_rdata, unused_data_in3, cpu_data_out3;
    logic [11:0] cpu_wr_addr3;

    axil2mpi_master #(.RD_LATENCY(3)) dut3 (
        .clks(clks), .reset_n(reset_n),
        .s_awvalid(1'b0), .s_awready(unused_awready3), .s_awaddr(32'h0),
        .s_wvalid(1'b0), .s_wready(unused_wready3), .s_wdata(32'h0), .s_wstrb(4'h0),
        .s_bvalid(unused_bvalid3), .s_bready(1'b0), .s_bresp(unused_bresp3),
        .s_arvalid(s3_arvalid), .s_arready(s3_arready), .s_araddr(s3_araddr),
        .s_rvalid(s3_rvalid), .s_rready(s3_rready), .s_rdata(s3_rdata), .s_rresp(unused_rresp3),
        .cpu_wr(cpu_wr3), .cpu_wr_addr(cpu_wr_addr3), .cpu_data_in(unused_data_in3),
        .cpu_rd(cpu_rd3), .cpu_data_out(cpu_data_out3)
    );

    // Register file models: read data is only valid in the latency cycle, garbage otherwise.
    logic [31:0] mem [0:4095] = '{default: 32'h0};
    logic        v1 = 1'b0;
    logic [31:0] d1 = 32'h0;
    logic [2:0]  v3 = 3'b000;
    logic [31:0] d3 [0:2] = '{default: 32'h0};

    function automatic logic [31:0] rf_read(input logic [11:0] a);
        if (a == 12'd4) return mem[2] + mem[3];
        return mem[a];
    endfunction

    always @(posedge clks) begin
        if (cpu_wr) mem[cpu_wr_addr] <= cpu_data_in;
        v1    <= cpu_rd;
        d1    <= rf_read(cpu_wr_addr);
        v3    <= {v3[1:0], cpu_rd3};
        d3[0] <= 32'hB000_0000 | {20'h0, cpu_wr_addr3};
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign cpu_data_out  = v1    ? d1    : 32'hDEAD_BEEF;
    assign cpu_data_out3 = v3[2] ? d3[2] : 32'hDEAD_BEEF;

    // Strobe monitor: counts pulses and flags overlapping or stretched strobes.
    int   wr_pulses = 0, rd_pulses = 0, strobe_err = 0;
    logic prev_wr = 1'b0, prev_rd = 1'b0;
    always @(posedge clks) begin
        if (cpu_wr) wr_pulses <= wr_pulses + 1;
        if (cpu_rd) rd_pulses <= rd_pulses + 1;
        if ((cpu_wr && cpu_rd) || (cpu_wr && prev_wr) || (cpu_rd && prev_rd) || (cpu_wr3 && cpu_rd3))
            strobe_err <= strobe_err + 1;
        prev_wr <= cpu_wr;
        prev_rd <= cpu_rd;
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // which=0: wait for AW/W acceptance, which=1: wait for AR acceptance.
    task automatic hs_wait(input int which, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            #1 ok = (which == 0) ? (s_awready && s_wready) : s_arready;
            @(negedge clks);
        end
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit got = 1'b0;
        resp = 2'b11;
        s_bready = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            #1 got = s_bvalid;
            if (got) resp = s_bresp;
            @(negedge clks);
        end
        s_bready = 1'b0;
        check("b_response_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
        bit got = 1'b0;
        data = 32'hFFFF_FFFF;
        resp = 2'b11;
        s_rready = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            #1 got = s_rvalid;
            if (got) begin data = s_rdata; resp = s_rresp; end
            @(negedge clks);
        end
        s_rready = 1'b0;
        check("r_response_seen", 32'(got), 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        bit ok;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        hs_wait(0, ok);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("aw_w_accepted", 32'(ok), 32'd1);
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ok;
        s_araddr = addr; s_arvalid = 1'b1;
        hs_wait(1, ok);
        s_arvalid = 1'b0;
        check("ar_accepted", 32'(ok), 32'd1);
        wait_r(data, resp);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_pulses;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        bit          ok, got, bad;
        int          p0, r0, rd_at, rv_at;

        vecs[0] = '{1'b1, 32'h0000_0008, 32'd5,         4'hF, 2'b00, 32'h0,         1};
        vecs[1] = '{1'b1, 32'h0000_000C, 32'd7,         4'hF, 2'b00, 32'h0,         1};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'd12,        0};
        vecs[3] = '{1'b1, 32'h0000_0018, 32'h1234_5678, 4'hF, 2'b00, 32'h0,         1};
        vecs[4] = '{1'b1, 32'h0000_0018, 32'hFFFF_FFFF, 4'h3, 2'b10, 32'h0,         0};
        vecs[5] = '{1'b0, 32'h0000_0018, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 0};
        vecs[6] = '{1'b1, 32'h4000_0020, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0,         1};
        vecs[7] = '{1'b0, 32'h0000_8022, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D, 0};
        vecs[8] = '{1'b1, 32'h0000_3FFC, 32'hA5A5_5A5A, 4'hF, 2'b00, 32'h0,         1};
        vecs[9] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b00, 32'hA5A5_5A5A, 0};

        // Reset values.
        repeat (3) @(negedge clks);
        #1 check("reset_outputs_zero", 32'(|{s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
                 s_rdata, s_rresp, cpu_wr, cpu_wr_addr, cpu_data_in, cpu_rd}), 32'd0);
        @(negedge clks);
        reset_n = 1'b1;
        @(negedge clks);

        // Arbitration after reset: write first, AR waits for the first IDLE cycle after bready.
        s_awaddr = 32'h040; s_wdata = 32'h11; s_wstrb = 4'hF; s_araddr = 32'h040;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        #1 check("arb_write_first", 32'({s_awready, s_wready, s_arready}), 32'b110);
        @(negedge clks);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        got = 1'b0; bad = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            #1 got = s_bvalid;
            if (s_arready) bad = 1'b1;
            @(negedge clks);
        end
        check("arb_bvalid_seen", 32'(got), 32'd1);
        s_bready = 1'b1;
        #1 check("arb_ar_blocked_in_resp", 32'({bad, s_arready}), 32'd0);
        @(negedge clks);
        s_bready = 1'b0;
        #1 check("arb_ar_first_idle", 32'(s_arready), 32'd1);
        @(negedge clks);
        s_arvalid = 1'b0;
        wait_r(data, resp);
        check("arb_read_sees_write", data, 32'h11);

        // Write served last, so a simultaneous request now goes to the read.
        axi_write(32'h044, 32'h22, 4'hF, resp);
        s_awaddr = 32'h044; s_wdata = 32'h33; s_wstrb = 4'hF; s_araddr = 32'h044;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        #1 check("arb_read_first", 32'({s_awready, s_wready, s_arready}), 32'b001);
        @(negedge clks);
        s_arvalid = 1'b0;
        wait_r(data, resp);
        check("arb_read_old_value", data, 32'h22);
        hs_wait(0, ok);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("arb_pending_write_accepted", 32'(ok), 32'd1);
        wait_b(resp);
        check("arb_pending_write_bresp", 32'(resp), 32'd0);

        // Table-driven single transactions.
        for (int i = 0; i < NV; i++) begin
            repeat (4) @(negedge clks);
            if (vecs[i].is_wr) begin
                p0 = wr_pulses;
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_wr_pulses", i), 32'(wr_pulses - p0), 32'(vecs[i].exp_pulses));
            end else begin
                axi_read(vecs[i].addr, data, resp);
                check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), 32'(resp), 32'd0);
            end
        end

        // AW without W is never accepted.
        s_awaddr = 32'h050; s_wdata = 32'h55; s_wstrb = 4'hF; s_awvalid = 1'b1; bad = 1'b0;
        repeat (8) begin
            #1 if (s_awready || s_wready) bad = 1'b1;
            @(negedge clks);
        end
        check("aw_without_w_blocked", 32'(bad), 32'd0);
        s_wvalid = 1'b1;
        #1 check("aw_w_pulse_together", 32'({s_awready, s_wready}), 32'b11);
        @(negedge clks);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_b(resp);
        check("aw_w_bresp", 32'(resp), 32'd0);

        // Read response stall with new requests pending (RD_LATENCY=1).
        s_araddr = 32'h008; s_arvalid = 1'b1;
        hs_wait(1, ok);
        s_arvalid = 1'b0;
        check("stall_ar_accepted", 32'(ok), 32'd1);
        rd_at = -1; rv_at = -1;
        for (int n = 0; n < 30 && rv_at < 0; n++) begin
            #1 if (cpu_rd && rd_at < 0) rd_at = n;
            if (s_rvalid) rv_at = n;
            @(negedge clks);
        end
        check("lat1_rd_to_rvalid", 32'(rv_at - rd_at), 32'd2);
        s_araddr = 32'h00C; s_arvalid = 1'b1;
        s_awaddr = 32'h008; s_wdata = 32'h99; s_awvalid = 1'b1; s_wvalid = 1'b1;
        p0 = wr_pulses; r0 = rd_pulses; bad = 1'b0;
        repeat (10) begin
            #1 if (!s_rvalid || s_rdata !== 32'd5 || s_arready || s_awready || s_wready) bad = 1'b1;
            @(negedge clks);
        end
        check("stall_rvalid_rdata_stable", 32'(bad), 32'd0);
        check("stall_no_strobes", 32'((wr_pulses - p0) + (rd_pulses - r0)), 32'd0);
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_r(data, resp);
        check("stall_rdata", data, 32'd5);

        // RD_LATENCY=3: rvalid four cycles after cpu_rd.
        s3_araddr = 32'h1C8; s3_arvalid = 1'b1; ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1 ok = s3_arready;
            @(negedge clks);
        end
        s3_arvalid = 1'b0;
        check("lat3_ar_accepted", 32'(ok), 32'd1);
        rd_at = -1; rv_at = -1;
        for (int n = 0; n < 30 && rv_at < 0; n++) begin
            #1 if (cpu_rd3 && rd_at < 0) rd_at = n;
            if (s3_rvalid) rv_at = n;
            @(negedge clks);
        end
        check("lat3_rd_to_rvalid", 32'(rv_at - rd_at), 32'd4);
        s3_rready = 1'b1;
        #1 check("lat3_rdata", s3_rdata, 32'hB000_0072);
        @(negedge clks);
        s3_rready = 1'b0;

        // Reset in RD_WAIT drops the read; a fresh read then completes.
        axi_write(32'h000, 32'h77, 4'hF, resp);
        s_araddr = 32'h100; s_arvalid = 1'b1;
        hs_wait(1, ok);
        s_arvalid = 1'b0;
        check("rst_ar_accepted", 32'(ok), 32'd1);
        @(negedge clks);
        #1 reset_n = 1'b0;
        #1 check("rst_outputs_zero", 32'(|{s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
                 s_rdata, s_rresp, cpu_wr, cpu_wr_addr, cpu_data_in, cpu_rd}), 32'd0);
        @(negedge clks);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            #1 if (s_rvalid) bad = 1'b1;
            @(negedge clks);
        end
        check("rst_aborted_read_dropped", 32'(bad), 32'd0);
        axi_read(32'h000, data, resp);
        check("rst_read_after_release", data, 32'h77);

        check("strobe_rules", 32'(strobe_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
